// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the serial receiver and the host data register.
// Latency: a byte pushed into an empty FIFO shows on host_dout one clk after rx_valid.
// Backpressure: cts drops at HIWATER and rises at LOWATER; a byte arriving while full is dropped and sets overrun.
//
// Ports:
//   clk, reset               falling-edge clock, synchronous active-high reset
//   rx_data/rx_frame_err     received byte and its framing flag, qualified by rx_valid
//   host_rd                  host data-register read select (level, may span cycles)
//   host_dout/frame_error    head entry, forced to 0 when empty
//   host_dor                 data available
//   overrun                  sticky dropped-byte flag, cleared by a host read
//   cts                      clear-to-send with high/low-water hysteresis
//   fill                     current entry count
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int HIWATER    = 12,
  parameter int LOWATER    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_frame_err,
  input  logic                  rx_valid,
  input  logic                  host_rd,
  output logic [7:0]            host_dout,
  output logic                  host_dor,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  cts,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HIWATER_C = (DEPTH_LOG2+1)'(HIWATER);
  localparam logic [DEPTH_LOG2:0] LOWATER_C = (DEPTH_LOG2+1)'(LOWATER);

  logic [8:0]            mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   next_count;
  logic                  host_rd_q;
  logic                  pop_ev;
  logic                  do_pop;
  logic                  do_push;
  logic                  drop;
  logic                  empty;
  logic [8:0]            head;

  assign empty = (count == '0);

  // Pop on the falling edge of the host access so the head stays stable
  // for the whole read.
  assign pop_ev  = !host_rd && host_rd_q;
  assign do_pop  = pop_ev && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push = rx_valid && ((count != DEPTH_C) || do_pop);
  assign drop    = rx_valid && !do_push;

  always_comb begin
    next_count = count;
    if (do_push && !do_pop)
      next_count = count + 1'b1;
    else if (do_pop && !do_push)
      next_count = count - 1'b1;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      cts       <= 1'b1;
      host_rd_q <= 1'b0;
    end else begin
      host_rd_q <= host_rd;
      count     <= next_count;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      // Set wins over clear if both land in one cycle.
      if (drop)
        overrun <= 1'b1;
      else if (pop_ev)
        overrun <= 1'b0;
      // Between the water marks cts keeps its last value (hysteresis).
      if (next_count >= HIWATER_C)
        cts <= 1'b0;
      else if (next_count <= LOWATER_C)
        cts <= 1'b1;
    end
  end

  // Storage is not reset; reads are masked while empty.
  always_ff @(negedge clk) begin
    if (!reset && do_push)
      mem[wr_ptr] <= {rx_frame_err, rx_data};
  end

  assign head        = mem[rd_ptr];
  assign host_dout   = empty ? 8'h00 : head[7:0];
  assign frame_error = empty ? 1'b0  : head[8];
  assign host_dor    = !empty;
  assign fill        = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       host_rd;
  logic [7:0] host_dout;
  logic       host_dor;
  logic       frame_error;
  logic       overrun;
  logic       cts;
  logic [4:0] fill;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .HIWATER(12), .LOWATER(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .host_rd      (host_rd),
    .host_dout    (host_dout),
    .host_dor     (host_dor),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .cts          (cts),
    .fill         (fill)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the active
  // (falling) edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic fe);
    rx_data      = b;
    rx_frame_err = fe;
    rx_valid     = 1'b1;
    tick();
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic pop();
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    rx_data      = 8'h00;
    rx_frame_err = 1'b0;
    rx_valid     = 1'b0;
    host_rd      = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_fill", 16'(fill), 16'd0);
    chk("rst_dor", 16'(host_dor), 16'd0);
    chk("rst_dout", 16'(host_dout), 16'h00);
    chk("rst_fe", 16'(frame_error), 16'd0);
    chk("rst_cts", 16'(cts), 16'd1);
    chk("rst_ovr", 16'(overrun), 16'd0);

    // 1: head stable across a multi-cycle read, pop on its end
    push(8'h41, 1'b0);
    chk("t1_first_visible", 16'(host_dout), 16'h41);
    push(8'h42, 1'b0);
    chk("t1_fill2", 16'(fill), 16'd2);
    chk("t1_dor", 16'(host_dor), 16'd1);
    chk("t1_head", 16'(host_dout), 16'h41);
    host_rd = 1'b1;
    tick();
    chk("t1_acc1", 16'(host_dout), 16'h41);
    tick();
    tick();
    chk("t1_acc3", 16'(host_dout), 16'h41);
    chk("t1_acc_fill", 16'(fill), 16'd2);
    host_rd = 1'b0;
    tick();
    chk("t1_after_dout", 16'(host_dout), 16'h42);
    chk("t1_after_fill", 16'(fill), 16'd1);
    pop();
    chk("t1_empty", 16'(fill), 16'd0);

    // 2: cts hysteresis
    for (int i = 0; i < 12; i++) begin
      push(8'(8'h10 + i), 1'b0);
      if (i == 10) chk("t2_cts_at11", 16'(cts), 16'd1);
    end
    chk("t2_fill12", 16'(fill), 16'd12);
    chk("t2_cts_at12", 16'(cts), 16'd0);
    for (int i = 0; i < 7; i++) pop();
    chk("t2_fill5", 16'(fill), 16'd5);
    chk("t2_cts_at5", 16'(cts), 16'd0);
    pop();
    chk("t2_fill4", 16'(fill), 16'd4);
    chk("t2_cts_at4", 16'(cts), 16'd1);
    for (int i = 0; i < 4; i++) pop();
    chk("t2_empty", 16'(fill), 16'd0);

    // 3: overrun on 17th byte, order preserved, cleared by first pop
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    chk("t3_fill16", 16'(fill), 16'd16);
    chk("t3_no_ovr", 16'(overrun), 16'd0);
    push(8'h10, 1'b0);
    chk("t3_fill_still16", 16'(fill), 16'd16);
    chk("t3_ovr", 16'(overrun), 16'd1);
    chk("t3_cts", 16'(cts), 16'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t3_seq", 16'(host_dout), 16'(i));
      pop();
      if (i == 0) chk("t3_ovr_clr", 16'(overrun), 16'd0);
    end
    chk("t3_empty", 16'(fill), 16'd0);
    chk("t3_dout_empty", 16'(host_dout), 16'h00);

    // 4: push coinciding with pop while full; pointers wrap
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
    chk("t4_full", 16'(fill), 16'd16);
    host_rd = 1'b1;
    tick();
    host_rd  = 1'b0;
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("t4_fill16", 16'(fill), 16'd16);
    chk("t4_no_ovr", 16'(overrun), 16'd0);
    chk("t4_head", 16'(host_dout), 16'h21);
    for (int i = 1; i < 16; i++) begin
      chk("t4_seq", 16'(host_dout), 16'(8'h20 + i));
      pop();
    end
    chk("t4_last", 16'(host_dout), 16'hAA);
    pop();
    chk("t4_empty", 16'(fill), 16'd0);
    chk("t4_cts", 16'(cts), 16'd1);

    // 5: framing flag follows its byte
    push(8'h55, 1'b1);
    push(8'h66, 1'b0);
    chk("t5_fe1", 16'(frame_error), 16'd1);
    chk("t5_d55", 16'(host_dout), 16'h55);
    pop();
    chk("t5_fe0", 16'(frame_error), 16'd0);
    chk("t5_d66", 16'(host_dout), 16'h66);
    pop();
    chk("t5_empty", 16'(fill), 16'd0);

    // 6: pop on empty ignored; reset mid-operation
    pop();
    chk("t6_empty_fill", 16'(fill), 16'd0);
    chk("t6_empty_dout", 16'(host_dout), 16'h00);
    chk("t6_empty_dor", 16'(host_dor), 16'd0);
    for (int i = 0; i < 13; i++) push(8'(8'h80 + i), 1'b0);
    chk("t6_cts13", 16'(cts), 16'd0);
    for (int i = 0; i < 6; i++) pop();
    chk("t6_fill7", 16'(fill), 16'd7);
    chk("t6_cts7", 16'(cts), 16'd0);
    host_rd = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_fill", 16'(fill), 16'd0);
    chk("t6_rst_cts", 16'(cts), 16'd1);
    chk("t6_rst_ovr", 16'(overrun), 16'd0);
    chk("t6_rst_dor", 16'(host_dor), 16'd0);
    reset = 1'b0;
    push(8'h77, 1'b0);
    chk("t6_push_during_rd", 16'(fill), 16'd1);
    host_rd = 1'b0;
    tick();
    tick();
    chk("t6_post_fill", 16'(fill), 16'd0);
    push(8'h78, 1'b0);
    tick();
    tick();
    chk("t6_no_stale_pop", 16'(fill), 16'd1);
    chk("t6_head", 16'(host_dout), 16'h78);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
